midsort_arbiter: RTL

- Shares one 3x3 median sorter (9 window inputs, fixed-latency, no backpressure) between two window requesters.
- Grants one window per cycle (round-robin or fixed priority), issues it to the sorter, tracks the requester id in an in-order tag FIFO, and routes each median back to its owner.
- Provides a halt/drain sequence so software can quiesce the sorter before reconfiguration.

---
 rtl/midsort_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/midsort_arbiter.sv
// midsort_arbiter
//   Two requesters share one fixed-latency 3x3 median sorter. One window is
//   granted per cycle (round-robin or fixed priority), registered into the
//   sorter, and the requester id is pushed into an in-order tag FIFO. Each
//   median leaving the sorter pops a tag and is routed back to its owner.
//   A halt/drain FSM lets software quiesce the sorter before reconfiguring it.
//
// Ports
//   clk, arstn           clock, synchronous active-low reset
//   cfg_prio_mode        0 = round-robin, 1 = fixed priority (req0 wins)
//   cfg_halt / halt_ack  stop-and-drain request / halted-and-drained status
//   reqN_valid/ready/win window request from requester N (ready = grant)
//   sort_din(_valid)     window issued to the sorter
//   sort_dout_data/valid median returned by the sorter
//   resN_data/valid      median routed to requester N
//   outstanding          windows in flight (tag FIFO count)
//   err_underflow        sticky: sorter result arrived with no tag
//
// Build option
//   MIDSORT_ARB_STATS_EN adds stat_grant0/stat_grant1, 16-bit saturating
//   per-requester handshake counters.
module midsort_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                             clk,
    input  logic                             arstn,
    input  logic                             cfg_prio_mode,
    input  logic                             cfg_halt,
    output logic                             halt_ack,
    input  logic                             req0_valid,
    output logic                             req0_ready,
    input  logic [9*DATA_WIDTH-1:0]          req0_win,
    input  logic                             req1_valid,
    output logic                             req1_ready,
    input  logic [9*DATA_WIDTH-1:0]          req1_win,
    output logic [9*DATA_WIDTH-1:0]          sort_din,
    output logic                             sort_din_valid,
    input  logic [DATA_WIDTH-1:0]            sort_dout_data,
    input  logic                             sort_dout_valid,
    output logic [DATA_WIDTH-1:0]            res0_data,
    output logic                             res0_valid,
    output logic [DATA_WIDTH-1:0]            res1_data,
    output logic                             res1_valid,
    output logic [$clog2(TAG_DEPTH):0]       outstanding,
    output logic                             err_underflow
`ifdef MIDSORT_ARB_STATS_EN
    ,
    output logic [15:0]                      stat_grant0,
    output logic [15:0]                      stat_grant1
`endif
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t                 state, state_nxt;
    logic                   rr_ptr;        // 0: req0 favoured on contention
    logic [TAG_DEPTH-1:0]   tag_mem;       // one bit per slot: owner id
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   issue_ok, gnt0, gnt1, push, pop, pop_id;

    // Full is judged on the registered count only, so a pop in the same
    // cycle never makes room for a push; this keeps the grant path short.
    assign issue_ok = (state == ST_RUN) && (count != CW'(TAG_DEPTH));

    assign gnt0 = issue_ok && req0_valid &&
                  (!req1_valid || cfg_prio_mode || !rr_ptr);
    assign gnt1 = issue_ok && req1_valid &&
                  (!req0_valid || (!cfg_prio_mode && rr_ptr));

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign push        = gnt0 || gnt1;
    assign pop         = sort_dout_valid && (count != '0);
    assign pop_id      = tag_mem[rd_ptr];
    assign outstanding = count;

    // Halt/drain FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (cfg_halt) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!cfg_halt)
                    state_nxt = ST_RUN;
                else if (count == '0 && !sort_dout_valid)
                    state_nxt = ST_HALTED;
            end
            ST_HALTED: if (!cfg_halt) state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // FSM state register; halt_ack is registered from the next state so it
    // is high exactly while the FSM sits in HALTED.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state    <= ST_RUN;
            halt_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            halt_ack <= (state_nxt == ST_HALTED);
        end
    end

    // Grant pointer, tag FIFO and error flag
    always_ff @(posedge clk) begin
        if (!arstn) begin
            rr_ptr        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
        end else begin
            // Pointer moves to whichever requester did not just win.
            if (push) rr_ptr <= gnt0;
            if (push) begin
                tag_mem[wr_ptr] <= gnt1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A result with no tag is dropped; stale results after a reset
            // land here too.
            if (sort_dout_valid && count == '0) err_underflow <= 1'b1;
        end
    end

    // Issue register: data holds while valid is low
    always_ff @(posedge clk) begin
        if (!arstn) begin
            sort_din       <= '0;
            sort_din_valid <= 1'b0;
        end else begin
            sort_din_valid <= push;
            if (push) sort_din <= gnt0 ? req0_win : req1_win;
        end
    end

    // Return routing: data of the non-owner holds
    always_ff @(posedge clk) begin
        if (!arstn) begin
            res0_data  <= '0;
            res0_valid <= 1'b0;
            res1_data  <= '0;
            res1_valid <= 1'b0;
        end else begin
            res0_valid <= pop && !pop_id;
            res1_valid <= pop && pop_id;
            if (pop && !pop_id) res0_data <= sort_dout_data;
            if (pop && pop_id)  res1_data <= sort_dout_data;
        end
    end

`ifdef MIDSORT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!arstn) begin
            stat_grant0 <= '0;
            stat_grant1 <= '0;
        end else begin
            if (gnt0 && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 1'b1;
            if (gnt1 && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 1'b1;
        end
    end
`endif

endmodule
